seg7_scan_counter: RTL and testbench

SEG7_SCAN_COUNTER -- requirements
Module: seg7_scan_counter

---
 rtl/seg7_scan_counter.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_counter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_counter.sv
// ============================================================================
// Module   : seg7_scan_counter
// Brief    : Multi-digit hex/BCD up/down counter with time-multiplexed
//            seven-segment drive (prescaled count step, independent scan).
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan_counter #(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV   = 10000000,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    bcd_mode,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    wrap
);

  localparam int c_pre_w  = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
  localparam int c_scan_w = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int c_idx_w  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_cnt_w  = 4 * NUM_DIGITS;

  localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(TICK_DIV - 1);
  localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
  localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(NUM_DIGITS - 1);

  logic [c_pre_w-1:0]    pre_q,   pre_d;
  logic [c_scan_w-1:0]   scan_q,  scan_d;
  logic [c_idx_w-1:0]    idx_q,   idx_d;
  logic [c_cnt_w-1:0]    count_q, count_d;
  logic [6:0]            seg_q,   seg_d;
  logic [NUM_DIGITS-1:0] sel_q,   sel_d;
  logic                  wrap_q,  wrap_d;

  logic                  w_tick;
  logic [c_cnt_w-1:0]    w_step;
  logic [c_cnt_w-1:0]    w_load_nib;
  logic [NUM_DIGITS:0]   w_chain;
  logic [3:0]            w_cur_digit;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
      4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
      4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
      4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Returns {carry/borrow out, new digit}. An out-of-range BCD digit rolls to
  // 0 with carry going up, but settles at 9 without borrow going down.
  function automatic logic [4:0] digit_step(input logic [3:0] d, input logic cin,
                                            input logic up, input logic bcd);
    logic [3:0] dmax;
    dmax = bcd ? 4'd9 : 4'hF;
    if (!cin)
      return {1'b0, d};
    if (up) begin
      if (d >= dmax)
        return {1'b1, 4'd0};
      return {1'b0, d + 4'd1};
    end
    if (bcd && (d > 4'd9))
      return {1'b0, 4'd9};
    if (d == 4'd0)
      return {1'b1, dmax};
    return {1'b0, d - 4'd1};
  endfunction

  assign w_chain[0] = 1'b1;

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      assign {w_chain[g+1], w_step[4*g +: 4]} =
        digit_step(count_q[4*g +: 4], w_chain[g], up_dn, bcd_mode);
      assign w_load_nib[4*g +: 4] =
        (bcd_mode && (load_val[4*g +: 4] > 4'd9)) ? 4'd9 : load_val[4*g +: 4];
    end
  endgenerate

  assign w_tick = en && (pre_q == c_pre_last);

  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = w_load_nib;
      pre_d   = '0;
    end else if (en) begin
      if (w_tick) begin
        pre_d   = '0;
        count_d = w_step;
        wrap_d  = w_chain[NUM_DIGITS];
      end else begin
        pre_d   = pre_q + 1'b1;
      end
    end
  end

  // Scan runs regardless of en/load so the display never freezes.
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == c_scan_last) begin
      scan_d = '0;
      idx_d  = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    w_cur_digit = count_q[3:0];
    sel_d       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == c_idx_w'(i)) begin
        w_cur_digit = count_q[4*i +: 4];
        sel_d[i]    = 1'b1;
      end
    end
    seg_d = seg_pattern(w_cur_digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      scan_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      seg_q   <= '0;
      sel_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      wrap_q  <= wrap_d;
    end
  end

  assign segments  = seg_q;
  assign digit_sel = sel_q;
  assign wrap      = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_counter.sv
// ============================================================================
// Module   : tb_seg7_scan_counter
// Brief    : Self-checking bench: cycle scoreboard plus load/step vector table.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_counter;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int SD = 2;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst_n, en, up_dn, bcd_mode, load;
  logic [7:0] load_val;
  logic [6:0] segments, seg1, seg4;
  logic [1:0] digit_sel;
  logic       dsel1;
  logic [3:0] dsel4;
  logic       wrap, wrap1, wrap4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_counter #(.NUM_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .bcd_mode(bcd_mode),
    .load(load), .load_val(load_val),
    .segments(segments), .digit_sel(digit_sel), .wrap(wrap));

  seg7_scan_counter #(.NUM_DIGITS(1), .TICK_DIV(TD), .SCAN_DIV(SD)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .bcd_mode(bcd_mode),
    .load(load), .load_val(load_val[3:0]),
    .segments(seg1), .digit_sel(dsel1), .wrap(wrap1));

  seg7_scan_counter #(.NUM_DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .bcd_mode(bcd_mode),
    .load(load), .load_val({8'h00, load_val}),
    .segments(seg4), .digit_sel(dsel4), .wrap(wrap4));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: whole-count arithmetic, digit by digit
  function automatic logic [8:0] m_step(input logic [7:0] c, input logic bcd, input logic up);
    int mx, d;
    logic carry;
    logic [7:0] r;
    mx = bcd ? 9 : 15;
    carry = 1'b1;
    r = c;
    for (int i = 0; i < N; i++) begin
      if (carry) begin
        d = int'(c[4*i +: 4]);
        if (up) begin
          if (d >= mx) begin d = 0; carry = 1'b1; end
          else begin d = d + 1; carry = 1'b0; end
        end else if (bcd && d > 9) begin
          d = 9; carry = 1'b0;
        end else if (d == 0) begin
          d = mx; carry = 1'b1;
        end else begin
          d = d - 1; carry = 1'b0;
        end
        r[4*i +: 4] = d[3:0];
      end
    end
    return {carry, r};
  endfunction

  function automatic logic [7:0] m_sat(input logic [7:0] v, input logic bcd);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < N; i++)
      if (bcd && v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  function automatic int seg_decode(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (SEG_TAB[i] == s) return i;
    return -1;
  endfunction

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] sel;
    logic       wrp;
    logic [3:0] sel4;
  } exp_t;

  exp_t       exp_q[$];
  int         m_pre, m_scan, m_idx, m_idx4;
  logic [7:0] m_cnt;
  logic       m_tick;
  logic [8:0] m_res;

  always_comb begin
    m_tick = en && (m_pre == TD - 1);
    m_res  = m_step(m_cnt, bcd_mode, up_dn);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre <= 0; m_scan <= 0; m_idx <= 0; m_idx4 <= 0; m_cnt <= 8'h00;
      exp_q.delete();
    end else begin
      exp_q.push_back({SEG_TAB[(m_idx == 0) ? m_cnt[3:0] : m_cnt[7:4]],
                       (m_idx == 0) ? 2'b01 : 2'b10,
                       (!load && m_tick && m_res[8]),
                       4'b0001 << m_idx4});
      if (load) begin
        m_cnt <= m_sat(load_val, bcd_mode);
        m_pre <= 0;
      end else if (m_tick) begin
        m_cnt <= m_res[7:0];
        m_pre <= 0;
      end else if (en) begin
        m_pre <= m_pre + 1;
      end
      if (m_scan == SD - 1) begin
        m_scan <= 0;
        m_idx  <= (m_idx + 1) % N;
        m_idx4 <= (m_idx4 + 1) % 4;
      end else begin
        m_scan <= m_scan + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outs", {segments, digit_sel, wrap, seg1, dsel1, wrap1, seg4, dsel4, wrap4}, '0);
    end else if (exp_q.size() > 0) begin
      chk("cycle", {segments, digit_sel, wrap}, {exp_q[0].seg, exp_q[0].sel, exp_q[0].wrp});
      chk("sel_n4", dsel4, exp_q[0].sel4);
      chk("sel_n1", dsel1, 1'b1);
      void'(exp_q.pop_front());
    end
  end

  task automatic apply_load(input logic [7:0] v, input logic bcd, input logic up);
    load_val = v; bcd_mode = bcd; up_dn = up; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Reassemble the displayed count from the multiplexed outputs
  task automatic read_disp(output logic [8:0] r);
    logic g0, g1;
    logic [7:0] v;
    int d;
    g0 = 1'b0; g1 = 1'b0; v = 8'h00;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8 && !(g0 && g1); k++) begin
      d = seg_decode(segments);
      if (digit_sel == 2'b01 && d >= 0) begin v[3:0] = d[3:0]; g0 = 1'b1; end
      if (digit_sel == 2'b10 && d >= 0) begin v[7:4] = d[3:0]; g1 = 1'b1; end
      @(negedge clk);
    end
    r = {g0 && g1, v};
  endtask

  typedef struct packed {
    logic       bl, br, up;
    logic [7:0] lv, el, es;
    logic       ew;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [8:0] rd;
    vt[0]  = {1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1};
    vt[1]  = {1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b1};
    vt[2]  = {1'b1, 1'b1, 1'b1, 8'h99, 8'h99, 8'h00, 1'b1};
    vt[3]  = {1'b1, 1'b1, 1'b1, 8'h3C, 8'h39, 8'h40, 1'b0};
    vt[4]  = {1'b1, 1'b1, 1'b0, 8'h3C, 8'h39, 8'h38, 1'b0};
    vt[5]  = {1'b0, 1'b0, 1'b1, 8'h0F, 8'h0F, 8'h10, 1'b0};
    vt[6]  = {1'b0, 1'b0, 1'b0, 8'h10, 8'h10, 8'h0F, 1'b0};
    vt[7]  = {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h99, 1'b1};
    vt[8]  = {1'b1, 1'b1, 1'b0, 8'h50, 8'h50, 8'h49, 1'b0};
    vt[9]  = {1'b0, 1'b1, 1'b1, 8'h3A, 8'h3A, 8'h40, 1'b0};
    vt[10] = {1'b0, 1'b1, 1'b0, 8'h3A, 8'h3A, 8'h39, 1'b0};
    vt[11] = {1'b1, 1'b1, 1'b1, 8'hA5, 8'h95, 8'h96, 1'b0};
    vt[12] = {1'b0, 1'b0, 1'b1, 8'h7F, 8'h7F, 8'h80, 1'b0};

    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; bcd_mode = 1'b0; load = 1'b0; load_val = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_edge", {segments, digit_sel, wrap}, {7'h3F, 2'b01, 1'b0});

    // Free-running hex count up: 16 steps from 00
    apply_load(8'h00, 1'b0, 1'b1);
    en = 1'b1;
    repeat (16 * TD) @(negedge clk);
    en = 1'b0;
    read_disp(rd);
    chk("freerun_16", rd, {1'b1, 8'h10});

    for (int i = 0; i < 13; i++) begin
      en = 1'b0;
      apply_load(vt[i].lv, vt[i].bl, vt[i].up);
      bcd_mode = vt[i].br;
      read_disp(rd);
      chk($sformatf("vec%0d_loaded", i), rd, {1'b1, vt[i].el});
      en = 1'b1;
      repeat (TD) @(negedge clk);
      en = 1'b0;
      chk($sformatf("vec%0d_wrap", i), wrap, vt[i].ew);
      @(negedge clk);
      chk($sformatf("vec%0d_wrap_end", i), wrap, 1'b0);
      read_disp(rd);
      chk($sformatf("vec%0d_step", i), rd, {1'b1, vt[i].es});
    end

    // Load coincident with a would-wrap tick: load wins, no wrap, full period follows
    apply_load(8'hFF, 1'b0, 1'b1);
    en = 1'b1;
    repeat (TD - 1) @(negedge clk);
    load_val = 8'h50; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("coinc_nowrap", wrap, 1'b0);
    repeat (TD - 1) @(negedge clk);
    en = 1'b0;
    read_disp(rd);
    chk("coinc_no_early_step", rd, {1'b1, 8'h50});
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    read_disp(rd);
    chk("coinc_step_at_4", rd, {1'b1, 8'h51});

    // Count frozen with en=0 while the scan keeps cycling
    repeat (10) @(negedge clk);
    read_disp(rd);
    chk("en0_frozen", rd, {1'b1, 8'h51});

    // Asynchronous reset mid-step at 0x27
    apply_load(8'h27, 1'b0, 1'b1);
    en = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {segments, digit_sel, wrap}, '0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", {segments, digit_sel, wrap}, {7'h3F, 2'b01, 1'b0});
    read_disp(rd);
    chk("rst_count", rd, {1'b1, 8'h00});
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
